// File: rtl/s3_ifetch.sv
// s3_ifetch: instruction fetch/decode front-end with program RAM and run/halt control
//   clk, rst            : clock, asynchronous active-high reset
//   pc                  : next-PC from the PC block (RAM read address while running)
//   wr_stb/addr/data    : host program-load port, one write per cycle, any state
//   run_req, halt_req   : start at ENTRY / stop execution (halt_req wins)
//   op_jmp, op_tgt, op_cond_inv/mask/val : jump request and condition to the PC block
//   op_exec, op_code, op_imm             : datapath op for the current cycle
//   running, halt_pulse, retired         : status, RUN->IDLE pulse, retired count
module s3_ifetch #(
    parameter int         INSN_W = 18,
    parameter logic [7:0] ENTRY  = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        pc,
    input  logic              wr_stb,
    input  logic [7:0]        wr_addr,
    input  logic [INSN_W-1:0] wr_data,
    input  logic              run_req,
    input  logic              halt_req,
    output logic              op_jmp,
    output logic [7:0]        op_tgt,
    output logic              op_cond_inv,
    output logic [3:0]        op_cond_mask,
    output logic [3:0]        op_cond_val,
    output logic              op_exec,
    output logic [4:0]        op_code,
    output logic [7:0]        op_imm,
    output logic              running,
    output logic              halt_pulse,
    output logic [15:0]       retired
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nx;
    logic [INSN_W-1:0] mem [256];
    logic [INSN_W-1:0] insn_q;
    logic [7:0] rd_addr;
    logic is_jmp, halt_dec, live;
    // Reading ENTRY while idle makes the run edge capture the first instruction
    // regardless of what the PC block presents.
    assign rd_addr  = state == RUN ? pc : ENTRY;
    assign is_jmp   = insn_q[17];
    assign halt_dec = state == RUN && !is_jmp && insn_q[16:12] == 5'h1F;
    // A decoded HALT already shows IDLE outputs in its own cycle.
    assign live     = state == RUN && !halt_dec;
    always_ff @(posedge clk) begin
        if (wr_stb) mem[wr_addr] <= wr_data;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            insn_q     <= '0;
            halt_pulse <= 1'b0;
            retired    <= '0;
        end else begin
            state      <= state_nx;
            insn_q     <= mem[rd_addr];
            halt_pulse <= state == RUN && state_nx == IDLE;
            retired    <= (state == IDLE && state_nx == RUN) ? 16'h0000 :
                          (live && retired != 16'hFFFF) ? retired + 16'h0001 : retired;
        end
    end
    always_comb begin
        state_nx = state == IDLE ? ((run_req && !halt_req) ? RUN : IDLE)
                                 : ((halt_dec || halt_req) ? IDLE : RUN);
    end
    always_comb begin
        op_jmp       = !live || is_jmp;
        op_tgt       = !live ? ENTRY : (is_jmp ? insn_q[7:0] : 8'h00);
        op_cond_inv  = live && is_jmp && insn_q[16];
        op_cond_mask = (live && is_jmp) ? insn_q[15:12] : 4'h0;
        op_cond_val  = (live && is_jmp) ? insn_q[11:8] : 4'h0;
        op_exec      = live && !is_jmp;
        op_code      = (live && !is_jmp) ? insn_q[16:12] : 5'h00;
        op_imm       = (live && !is_jmp) ? insn_q[7:0] : 8'h00;
        running      = live;
    end
endmodule

// File: tb/tb_s3_ifetch.sv
// tb_s3_ifetch: directed self-checking bench for s3_ifetch
module tb_s3_ifetch;
    logic clk = 1'b0, rst = 1'b1;
    logic [7:0] pc = 8'h00, wr_addr = 8'h00;
    logic wr_stb = 1'b0, run_req = 1'b0, halt_req = 1'b0;
    logic [17:0] wr_data = '0;
    logic op_jmp, op_cond_inv, op_exec, running, halt_pulse;
    logic [7:0] op_tgt, op_imm;
    logic [3:0] op_cond_mask, op_cond_val;
    logic [4:0] op_code;
    logic [15:0] retired;
    logic [33:0] obs;
    int vecs = 0, errs = 0;
    // {op_jmp, op_tgt, inv, mask, val, op_exec, op_code, op_imm, running, halt_pulse}
    localparam logic [33:0] IDLE_V = {1'b1, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0};
    localparam logic [33:0] IDLE_P = {1'b1, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b1};
    s3_ifetch dut (
        .clk(clk), .rst(rst), .pc(pc), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
        .run_req(run_req), .halt_req(halt_req), .op_jmp(op_jmp), .op_tgt(op_tgt),
        .op_cond_inv(op_cond_inv), .op_cond_mask(op_cond_mask), .op_cond_val(op_cond_val),
        .op_exec(op_exec), .op_code(op_code), .op_imm(op_imm), .running(running),
        .halt_pulse(halt_pulse), .retired(retired)
    );
    assign obs = {op_jmp, op_tgt, op_cond_inv, op_cond_mask, op_cond_val, op_exec, op_code, op_imm, running, halt_pulse};
    always #5 clk = ~clk;
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic wr(input logic [7:0] a, input logic [17:0] d);
        wr_stb = 1'b1; wr_addr = a; wr_data = d;
        step(1);
        wr_stb = 1'b0;
    endtask
    task automatic start_run();
        pc = 8'h00; run_req = 1'b1;
        step(1);
        run_req = 1'b0;
    endtask
    task automatic test_reset();
        step(2);
        #2 rst = 1'b0;
        step(3);
        vecs++; if (obs !== IDLE_V) begin errs++; $display("FAIL reset_outputs got %h want %h", obs, IDLE_V); end
        vecs++; if (retired !== 16'h0000) begin errs++; $display("FAIL reset_retired got %h want 0000", retired); end
    endtask
    task automatic test_op_halt();
        logic [33:0] exp_op;
        exp_op = {1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b1, 5'h01, 8'h34, 1'b1, 1'b0};
        wr(8'h00, 18'h01234);
        wr(8'h01, 18'h1F000);
        start_run();
        pc = 8'h01;
        vecs++; if (obs !== exp_op) begin errs++; $display("FAIL op_decode got %h want %h", obs, exp_op); end
        vecs++; if (retired !== 16'h0000) begin errs++; $display("FAIL op_retired got %h want 0000", retired); end
        step(1);
        vecs++; if ({op_jmp, op_tgt, op_exec} !== {1'b1, 8'h00, 1'b0}) begin errs++; $display("FAIL halt_forced_jmp got %b/%h/%b want 1/00/0", op_jmp, op_tgt, op_exec); end
        vecs++; if (halt_pulse !== 1'b0) begin errs++; $display("FAIL halt_pulse_early got %b want 0", halt_pulse); end
        step(1);
        vecs++; if (obs !== IDLE_P) begin errs++; $display("FAIL halt_idle_pulse got %h want %h", obs, IDLE_P); end
        vecs++; if (retired !== 16'h0001) begin errs++; $display("FAIL halt_retired got %h want 0001", retired); end
        step(1);
        vecs++; if (obs !== IDLE_V) begin errs++; $display("FAIL halt_pulse_single got %h want %h", obs, IDLE_V); end
    endtask
    task automatic test_jump_and_both_req();
        logic [33:0] exp_j;
        exp_j = {1'b1, 8'h55, 1'b0, 4'h3, 4'hA, 1'b0, 5'h00, 8'h00, 1'b1, 1'b0};
        wr(8'h00, 18'h23A55);
        start_run();
        vecs++; if (obs !== exp_j) begin errs++; $display("FAIL jump_decode got %h want %h", obs, exp_j); end
        step(1);
        vecs++; if (obs !== exp_j) begin errs++; $display("FAIL jump_hold_run got %h want %h", obs, exp_j); end
        halt_req = 1'b1; run_req = 1'b1;
        step(1);
        halt_req = 1'b0; run_req = 1'b0;
        vecs++; if (obs !== IDLE_P) begin errs++; $display("FAIL both_req_idle got %h want %h", obs, IDLE_P); end
        step(1);
        vecs++; if (obs !== IDLE_V) begin errs++; $display("FAIL both_req_pulse_end got %h want %h", obs, IDLE_V); end
    endtask
    task automatic test_read_first();
        wr(8'h00, 18'h01234);
        wr(8'h05, 18'h02011);
        start_run();
        pc = 8'h05; wr_stb = 1'b1; wr_addr = 8'h05; wr_data = 18'h03022;
        step(1);
        wr_stb = 1'b0;
        vecs++; if ({op_exec, op_code, op_imm} !== {1'b1, 5'h02, 8'h11}) begin errs++; $display("FAIL read_first_old got %b/%h/%h want 1/02/11", op_exec, op_code, op_imm); end
        step(1);
        vecs++; if ({op_exec, op_code, op_imm} !== {1'b1, 5'h03, 8'h22}) begin errs++; $display("FAIL read_first_new got %b/%h/%h want 1/03/22", op_exec, op_code, op_imm); end
    endtask
    task automatic test_rst_mid_run();
        vecs++; if (running !== 1'b1) begin errs++; $display("FAIL pre_rst_running got %b want 1", running); end
        #2 rst = 1'b1;
        #1;
        vecs++; if (obs !== IDLE_V) begin errs++; $display("FAIL async_rst_idle got %h want %h", obs, IDLE_V); end
        vecs++; if (retired !== 16'h0000) begin errs++; $display("FAIL async_rst_retired got %h want 0000", retired); end
        step(1);
        #2 rst = 1'b0;
        step(1);
    endtask
    task automatic test_saturate();
        wr(8'h00, 18'h20000);
        start_run();
        vecs++; if ({op_jmp, op_tgt, running} !== {1'b1, 8'h00, 1'b1}) begin errs++; $display("FAIL loop_decode got %b/%h/%b want 1/00/1", op_jmp, op_tgt, running); end
        step(70000);
        vecs++; if (retired !== 16'hFFFF) begin errs++; $display("FAIL retired_saturate got %h want ffff", retired); end
        vecs++; if (running !== 1'b1) begin errs++; $display("FAIL loop_still_running got %b want 1", running); end
        halt_req = 1'b1;
        step(1);
        halt_req = 1'b0;
        vecs++; if (obs !== IDLE_P) begin errs++; $display("FAIL halt_req_stop got %h want %h", obs, IDLE_P); end
        start_run();
        vecs++; if (retired !== 16'h0000) begin errs++; $display("FAIL run_clears_retired got %h want 0000", retired); end
        step(1);
        vecs++; if (retired !== 16'h0001) begin errs++; $display("FAIL retired_restart got %h want 0001", retired); end
    endtask
    initial begin
        test_reset();
        test_op_halt();
        test_jump_and_both_req();
        test_read_first();
        test_rst_mid_run();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
